ctrl_banda: RTL and testbench

Controller and arbiter for a bank of `reg_banda` band registers. It shares the bank between a write requester (coefficient/configuration loader) and a read requester (filter datapath). It serializes their accesses through a request/acknowledge handshake and generates per-band `escribir`/`leer` strobes and the shared input bus. It sits between the requesters and `NBANDAS` instances of `reg_banda`.

---
 rtl/ctrl_banda.sv | 152 +++++++++++++++
 tb/tb_ctrl_banda.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_banda.sv
// Arbiter/controller sharing a bank of reg_banda registers between a writer and a reader.
// Define CTRL_BANDA_RR_EN for round-robin arbitration; otherwise writes have fixed priority.
module ctrl_banda #(
    parameter int unsigned ANCHO   = 25,
    parameter int unsigned NBANDAS = 4,
    parameter int unsigned IDX     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic [IDX-1:0]           wr_idx,
    input  logic [ANCHO-1:0]         wr_dato,
    output logic                     wr_ack,
    input  logic                     rd_req,
    input  logic [IDX-1:0]           rd_idx,
    output logic                     rd_ack,
    output logic [ANCHO-1:0]         rd_dato,
    output logic                     err,
    output logic [NBANDAS-1:0]       escribir,
    output logic [NBANDAS-1:0]       leer,
    output logic [ANCHO-1:0]         in_banda,
    input  logic [NBANDAS*ANCHO-1:0] out_banda
);

    typedef enum logic [2:0] {IDLE, ESCRIBE, ACK_E, LEE, ESPERA, ACK_L} estado_t;

    estado_t              estado_q, estado_d;
    logic [IDX-1:0]       idx_q, idx_d;
    logic [ANCHO-1:0]     in_banda_q, in_banda_d;
    logic [ANCHO-1:0]     rd_dato_q, rd_dato_d;
    logic [NBANDAS-1:0]   escribir_q, escribir_d;
    logic [NBANDAS-1:0]   leer_q, leer_d;
    logic                 wr_ack_q, wr_ack_d;
    logic                 rd_ack_q, rd_ack_d;
    logic                 err_q, err_d;
    logic                 gana_wr;
    logic [ANCHO-1:0]     dato_sel;

    // An out-of-range index decodes to all zeros, so no strobe fires for it.
    function automatic logic [NBANDAS-1:0] decodifica(input logic [IDX-1:0] i);
        logic [NBANDAS-1:0] oh;
        oh = '0;
        for (int unsigned k = 0; k < NBANDAS; k++) oh[k] = (32'(i) == k);
        return oh;
    endfunction

    function automatic logic en_rango(input logic [IDX-1:0] i);
        return 32'(i) < NBANDAS;
    endfunction

`ifdef CTRL_BANDA_RR_EN
    logic last_q, last_d;  // 1: the read requester was served last
    assign gana_wr = wr_req && (!rd_req || last_q);
`else
    assign gana_wr = wr_req;
`endif

    always_comb begin
        dato_sel = '0;
        for (int unsigned k = 0; k < NBANDAS; k++)
            if (32'(idx_q) == k) dato_sel = out_banda[k*ANCHO +: ANCHO];
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        estado_d   = estado_q;
        idx_d      = idx_q;
        in_banda_d = in_banda_q;
        rd_dato_d  = rd_dato_q;
        escribir_d = '0;
        leer_d     = '0;
        wr_ack_d   = 1'b0;
        rd_ack_d   = 1'b0;
        err_d      = 1'b0;
`ifdef CTRL_BANDA_RR_EN
        last_d     = last_q;
`endif
        case (estado_q)
            IDLE: begin
                if (gana_wr) begin
                    estado_d   = ESCRIBE;
                    idx_d      = wr_idx;
                    in_banda_d = wr_dato;
                    escribir_d = decodifica(wr_idx);
`ifdef CTRL_BANDA_RR_EN
                    last_d     = 1'b0;
`endif
                end else if (rd_req) begin
                    estado_d = LEE;
                    idx_d    = rd_idx;
                    leer_d   = decodifica(rd_idx);
`ifdef CTRL_BANDA_RR_EN
                    last_d   = 1'b1;
`endif
                end
            end
            ESCRIBE: begin
                estado_d = ACK_E;
                wr_ack_d = 1'b1;
                err_d    = !en_rango(idx_q);
            end
            LEE:    estado_d = ESPERA;
            ESPERA: begin
                estado_d  = ACK_L;
                rd_ack_d  = 1'b1;
                err_d     = !en_rango(idx_q);
                rd_dato_d = dato_sel;
            end
            default: estado_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= IDLE;
            idx_q      <= '0;
            in_banda_q <= '0;
            rd_dato_q  <= '0;
            escribir_q <= '0;
            leer_q     <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            err_q      <= 1'b0;
`ifdef CTRL_BANDA_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            estado_q   <= estado_d;
            idx_q      <= idx_d;
            in_banda_q <= in_banda_d;
            rd_dato_q  <= rd_dato_d;
            escribir_q <= escribir_d;
            leer_q     <= leer_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            err_q      <= err_d;
`ifdef CTRL_BANDA_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign wr_ack   = wr_ack_q;
    assign rd_ack   = rd_ack_q;
    assign rd_dato  = rd_dato_q;
    assign err      = err_q;
    assign escribir = escribir_q;
    assign leer     = leer_q;
    assign in_banda = in_banda_q;

endmodule

// File: tb/tb_ctrl_banda.sv
// Bench for ctrl_banda with three bands and a two-bit index, so index 3 is out of range.
// A transaction-level model schedules the expected outputs per cycle; a monitor compares them.
module tb_ctrl_banda;

    localparam int unsigned ANCHO = 25;
    localparam int unsigned NB    = 3;
    localparam int unsigned IDXW  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                wr_req, rd_req;
    logic [IDXW-1:0]     wr_idx, rd_idx;
    logic [ANCHO-1:0]    wr_dato;
    logic                wr_ack, rd_ack, err;
    logic [ANCHO-1:0]    rd_dato, in_banda;
    logic [NB-1:0]       escribir, leer;
    logic [NB*ANCHO-1:0] out_banda;

    ctrl_banda #(.ANCHO(ANCHO), .NBANDAS(NB), .IDX(IDXW)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_dato(wr_dato), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_dato(rd_dato),
        .err(err), .escribir(escribir), .leer(leer), .in_banda(in_banda),
        .out_banda(out_banda)
    );

    always #5 clk = ~clk;

    // Band registers seen by the controller.
    logic [ANCHO-1:0] bank [NB];
    logic [ANCHO-1:0] bout [NB];
    assign out_banda = {bout[2], bout[1], bout[0]};
    always @(posedge clk)
        for (int k = 0; k < NB; k++) begin
            if (escribir[k]) bank[k] <= in_banda;
            if (leer[k])     bout[k] <= bank[k];
        end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Transaction-level model: on each accepted request, schedule outputs by cycle number.
    logic [NB-1:0]    exp_esc  [int];
    logic [NB-1:0]    exp_leer [int];
    bit               exp_wack [int];
    bit               exp_rack [int];
    bit               exp_err  [int];
    logic [ANCHO-1:0] upd_in   [int];
    logic [ANCHO-1:0] upd_rd   [int];
    logic [ANCHO-1:0] shadow   [NB];
    int  ecount = 0, e, next_free = 0;
    bit  model_valid = 0, last_rd = 1, do_wr, done = 0;
    logic [ANCHO-1:0] cur_in, cur_rd;

    function automatic logic [NB-1:0] onehot(input int i);
        return (i < NB) ? NB'(1 << i) : '0;
    endfunction

    always @(posedge clk) begin
        e = ecount;
        if (reset) begin
            exp_esc.delete(); exp_leer.delete(); exp_wack.delete();
            exp_rack.delete(); exp_err.delete(); upd_in.delete(); upd_rd.delete();
            upd_in[e+1] = '0;
            upd_rd[e+1] = '0;
            next_free   = e + 1;
            last_rd     = 1;
            model_valid = 1;
        end else if (model_valid && e >= next_free) begin
`ifdef CTRL_BANDA_RR_EN
            do_wr = wr_req && (!rd_req || last_rd);
`else
            do_wr = wr_req;
`endif
            if (do_wr) begin
                exp_esc[e+1]  = onehot(int'(wr_idx));
                exp_wack[e+2] = 1;
                exp_err[e+2]  = (wr_idx >= NB);
                upd_in[e+1]   = wr_dato;
                if (wr_idx < NB) shadow[wr_idx] = wr_dato;
                next_free     = e + 3;
                last_rd       = 0;
            end else if (rd_req) begin
                exp_leer[e+1] = onehot(int'(rd_idx));
                exp_rack[e+3] = 1;
                exp_err[e+3]  = (rd_idx >= NB);
                upd_rd[e+3]   = (rd_idx < NB) ? shadow[rd_idx] : '0;
                next_free     = e + 4;
                last_rd       = 1;
            end
        end
        ecount++;
    end

    always @(negedge clk) begin
        if (model_valid && !done) begin
            int c;
            c = ecount;
            if (upd_in.exists(c)) cur_in = upd_in[c];
            if (upd_rd.exists(c)) cur_rd = upd_rd[c];
            check("escribir", 32'(escribir), 32'(exp_esc.exists(c)  ? exp_esc[c]  : '0));
            check("leer",     32'(leer),     32'(exp_leer.exists(c) ? exp_leer[c] : '0));
            check("wr_ack",   32'(wr_ack),   32'(exp_wack.exists(c) ? exp_wack[c] : 1'b0));
            check("rd_ack",   32'(rd_ack),   32'(exp_rack.exists(c) ? exp_rack[c] : 1'b0));
            check("err",      32'(err),      32'(exp_err.exists(c)  ? exp_err[c]  : 1'b0));
            check("in_banda", 32'(in_banda), 32'(cur_in));
            check("rd_dato",  32'(rd_dato),  32'(cur_rd));
            check("strobe_exclusive", 32'($countones({escribir, leer}) <= 1), 32'd1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    bit         seen;
    int         n_acks;
    logic [3:0] orden;

    initial begin
        for (int k = 0; k < NB; k++) begin
            bank[k] = '0; bout[k] = '0; shadow[k] = '0;
        end
        reset = 1; wr_req = 0; rd_req = 0; wr_idx = '0; rd_idx = '0; wr_dato = '0;
        cyc(2);
        reset = 0;
        cyc(1);

        // Write band 2 then read it back.
        wr_req = 1; wr_idx = 2; wr_dato = 25'h0F83E0;
        cyc(1); check("wr_strobe_band2", 32'(escribir), 32'b100);
                check("wr_no_early_ack", 32'(wr_ack), 32'd0);
        cyc(1); check("wr_strobe_one_cycle", 32'(escribir), 32'd0);
                check("wr_ack_latency", 32'(wr_ack), 32'd1);
                wr_req = 0;
        cyc(1); rd_req = 1; rd_idx = 2;
        cyc(1); check("rd_strobe_band2", 32'(leer), 32'b100);
        cyc(1); check("rd_no_early_ack", 32'(rd_ack), 32'd0);
        cyc(1); check("rd_ack_latency", 32'(rd_ack), 32'd1);
                check("rd_dato_band2", 32'(rd_dato), 32'h0F83E0);
                rd_req = 0;
        cyc(1);

        // Out-of-range read.
        rd_req = 1; rd_idx = 3;
        cyc(1); check("oor_no_leer", 32'(leer), 32'd0);
        cyc(2); check("oor_rd_ack", 32'(rd_ack), 32'd1);
                check("oor_err", 32'(err), 32'd1);
                check("oor_rd_dato_zero", 32'(rd_dato), 32'd0);
                rd_req = 0;
        cyc(1);

        // Data change during ESCRIBE must not reach the band.
        wr_req = 1; wr_idx = 1; wr_dato = 25'h1555555;
        cyc(1); wr_dato = '0;
                check("mid_in_banda", 32'(in_banda), 32'h1555555);
        cyc(1); wr_req = 0;
        cyc(1); rd_req = 1; rd_idx = 1;
        cyc(3); check("mid_readback", 32'(rd_dato), 32'h1555555);
                rd_req = 0;
        cyc(1);

        // Reset during LEE abandons the read.
        rd_req = 1; rd_idx = 2;
        cyc(1); check("rst_leer_seen", 32'(leer), 32'b100);
                reset = 1; rd_req = 0;
        cyc(1); reset = 0;
                check("rst_strobes", 32'({escribir, leer}), 32'd0);
                check("rst_acks", 32'({wr_ack, rd_ack, err}), 32'd0);
                check("rst_rd_dato", 32'(rd_dato), 32'd0);
                check("rst_in_banda", 32'(in_banda), 32'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (rd_ack) seen = 1;
        end
        check("rst_no_rd_ack", 32'(seen), 32'd0);

        // Both requests held high from reset.
        reset = 1; wr_req = 1; rd_req = 1; wr_idx = 0; rd_idx = 1; wr_dato = 25'h0ABCDE;
        cyc(1); reset = 0;
        n_acks = 0; orden = '0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if ((wr_ack || rd_ack) && n_acks < 4) begin
                orden[n_acks] = rd_ack;
                n_acks++;
            end
        end
        check("simul_ack_count", 32'(n_acks), 32'd4);
`ifdef CTRL_BANDA_RR_EN
        check("simul_order", 32'(orden), 32'b1010);
`else
        check("simul_order", 32'(orden), 32'b0000);
`endif
        wr_req = 0;
        seen = 0;
        for (int i = 0; i < 16 && !seen; i++) begin
            cyc(1);
            if (rd_ack) begin seen = 1; rd_req = 0; end
        end
        check("simul_read_drains", 32'(seen), 32'd1);
        rd_req = 0;
        cyc(2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(1);
            reset = ($urandom_range(0, 149) == 0);
            if (!wr_req || wr_ack) begin
                wr_req = ($urandom_range(0, 3) == 0);
                if (wr_req) begin
                    wr_idx  = IDXW'($urandom_range(0, 3));
                    wr_dato = ANCHO'($urandom);
                end
            end else if ($urandom_range(0, 7) == 0) begin
                wr_dato = ANCHO'($urandom);
            end
            if (!rd_req || rd_ack) begin
                rd_req = ($urandom_range(0, 2) == 0);
                if (rd_req) rd_idx = IDXW'($urandom_range(0, 3));
            end else if ($urandom_range(0, 7) == 0) begin
                rd_idx = IDXW'($urandom_range(0, 3));
            end
        end
        reset = 0; wr_req = 0; rd_req = 0;
        cyc(8);
        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
